// File: rtl/booth_divider.sv
// Sequential signed restoring divider with a start/done handshake.
// One quotient bit per clock on operand magnitudes, then a sign-fix cycle.
module booth_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_diff;
  logic             take;

  // Magnitudes and the shift/trial-subtract step for the current iteration.
  always_comb begin
    dvd_abs = dvd_neg ? (WIDTH'(0) - dvd_r) : dvd_r;
    dvs_abs = dvs_neg ? (WIDTH'(0) - dvs_r) : dvs_r;
    r_sh    = {r_r[WIDTH-1:0], q_r[WIDTH-1]};
    r_diff  = r_sh - {1'b0, dvs_mag};
    // A bit shifted out of R means the shifted value exceeds any divisor.
    take    = r_r[WIDTH] | (r_sh >= {1'b0, dvs_mag});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_r       <= '0;
      dvs_r       <= '0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      dvs_mag     <= '0;
      r_r         <= '0;
      q_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_r       <= dividend;
            dvs_r       <= divisor;
            dvd_neg     <= dividend[WIDTH-1];
            dvs_neg     <= divisor[WIDTH-1];
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          r_r     <= '0;
          q_r     <= dvd_abs;
          dvs_mag <= dvs_abs;
          cnt     <= CW'(WIDTH);
          if (dvs_r == '0) begin
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= dvd_r;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          r_r <= take ? r_diff : r_sh;
          q_r <= {q_r[WIDTH-2:0], take};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient  <= (dvd_neg ^ dvs_neg) ? (WIDTH'(0) - q_r) : q_r;
          remainder <= dvd_neg ? (WIDTH'(0) - r_r[WIDTH-1:0]) : r_r[WIDTH-1:0];
          ovf       <= (dvd_r == MIN_NEG) && (dvs_r == '1);
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Randomized self-checking bench for booth_divider against an integer-arithmetic model.
module tb_booth_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  booth_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Signed division truncates toward zero and % takes the dividend's sign.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
    int ai;
    int bi;
    int qi;
    int qmax;
    ai   = int'($signed(a));
    bi   = int'($signed(b));
    qmax = (1 << (W - 1)) - 1;
    dz   = (bi == 0);
    ov   = 1'b0;
    if (dz) begin
      q = '1;
      r = a;
    end else begin
      qi = ai / bi;
      q  = W'(qi);
      r  = W'(ai % bi);
      ov = (qi > qmax);
    end
  endfunction

  // Call at a negedge with the DUT idle; returns at the negedge after the done cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit repulse);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    logic         eov;
    int           lat;
    int           cyc;
    bit           busy_ok;
    bit           seen;
    ref_div(a, b, eq, er, edz, eov);
    lat = edz ? 2 : int'(W) + 3;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    cyc      = 0;
    busy_ok  = 1'b1;
    seen     = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (repulse && cyc == 4) begin
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      if (repulse && cyc == 5) start = 1'b0;
      if (busy !== (cyc < lat)) busy_ok = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    check_val({tag, " latency"}, cyc, lat);
    check_val({tag, " quotient"}, quotient, eq);
    check_val({tag, " remainder"}, remainder, er);
    check_val({tag, " div_by_zero"}, div_by_zero, edz);
    check_val({tag, " ovf"}, ovf, eov);
    check_val({tag, " busy"}, busy_ok, 1);
    @(negedge clk);
    check_val({tag, " done_pulse"}, done, 0);
    check_val({tag, " hold"}, {quotient, remainder}, {eq, er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ta [8];
    logic [W-1:0] tb [8];
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    logic         eov;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           done_cyc [3];
    int           ndone;
    int           cyc;
    bit           saw_done;

    ta = '{8'd100, 8'h9C, 8'd100, 8'h9C, 8'h25, 8'h80, 8'h80, 8'h7F};
    tb = '{8'd7,   8'd7,  8'hF9,  8'hF9, 8'h00, 8'hFF, 8'h01, 8'h7F};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check_val("reset outputs", {quotient, remainder, busy, done, div_by_zero, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("dir%0d", i), ta[i], tb[i], 1'b0);
    end

    run_op("repulse", 8'd100, 8'd7, 1'b1);

    // Start held high: one operation every W+4 cycles.
    ref_div(8'h9C, 8'd7, eq, er, edz, eov);
    dividend = 8'h9C;
    divisor  = 8'd7;
    start    = 1'b1;
    ndone    = 0;
    cyc      = 0;
    while (ndone < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        done_cyc[ndone] = cyc;
        ndone++;
        check_val($sformatf("held q%0d", ndone), {quotient, remainder}, {eq, er});
      end
    end
    start = 1'b0;
    check_val("held count", ndone, 3);
    if (ndone == 3) begin
      check_val("held first", done_cyc[0], int'(W) + 3);
      check_val("held gap1", done_cyc[1] - done_cyc[0], int'(W) + 4);
      check_val("held gap2", done_cyc[2] - done_cyc[1], int'(W) + 4);
    end
    @(negedge clk);

    // Reset asserted off-edge during the fourth ITER cycle.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check_val("midop busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("midop reset", {quotient, remainder, busy, done, div_by_zero, ovf}, 0);
    saw_done = 1'b0;
    @(negedge clk);
    if (done === 1'b1) saw_done = 1'b1;
    @(negedge clk);
    if (done === 1'b1) saw_done = 1'b1;
    #2;
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check_val("midop no_done", saw_done, 0);
    run_op("post_reset", 8'd55, 8'd5, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
      if (i == 10) begin
        a = 8'h80;
        b = 8'hFF;
      end
      run_op($sformatf("rnd%0d", i), a, b, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
